// File: rtl/ac97_link_engine.sv
// AC-link frame engine: serialises tag/command/PCM slots to the codec and decodes the
// returning frame into codec-ready, register read-back and stereo PCM-in outputs.
module ac97_link_engine #(
    parameter int unsigned SAMPLE_W = 20,
    parameter int unsigned NUM_CH   = 2
) (
    input  logic                       ac97_bitclk,
    input  logic                       ac97_rst_b,
    input  logic                       ac97_sdata_in,
    output logic                       ac97_sdata_out,
    output logic                       ac97_sync,
    output logic                       ac97_reset_b,
    output logic                       frame_strobe,
    input  logic [NUM_CH*SAMPLE_W-1:0] pcm_out,
    input  logic [NUM_CH-1:0]          pcm_out_valid,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic                       cmd_write,
    input  logic [6:0]                 cmd_addr,
    input  logic [15:0]                cmd_data,
    output logic                       codec_ready,
    output logic                       status_valid,
    output logic [6:0]                 status_addr,
    output logic [15:0]                status_data,
    output logic [1:0]                 pcm_in_valid,
    output logic [SAMPLE_W-1:0]        pcm_in_l,
    output logic [SAMPLE_W-1:0]        pcm_in_r
);

    // Frame vectors are MSB-first: link bit i lives at vector index 255-i.
    logic [7:0]   bit_cnt_q, bit_cnt_d;
    logic         frame_end;
    logic         sync_d;
    logic [255:0] tx_q, rx_q, frame_d;
    logic [15:0]  tx_tag;
    logic [19:0]  pcm_slot;
    logic         pending_q, pend_write_q;
    logic [6:0]   pend_addr_q;
    logic [15:0]  pend_data_q;
    logic         cmd_accept;
    logic         unused_rx;

    assign frame_end  = (bit_cnt_q == 8'hFF);
    assign bit_cnt_d  = bit_cnt_q + 8'd1;
    assign sync_d     = (bit_cnt_d == 8'hFF) || (bit_cnt_d < 8'd15);
    assign cmd_ready  = !pending_q;
    assign cmd_accept = cmd_valid && !pending_q;
    assign unused_rx  = ^rx_q;

    always_comb begin
        frame_d  = '0;
        tx_tag   = 16'h8000;
        pcm_slot = '0;
        if (pending_q) begin
            tx_tag[14]        = 1'b1;
            frame_d[239:220]  = {~pend_write_q, pend_addr_q, 12'b0};
            if (pend_write_q) begin
                tx_tag[13]       = 1'b1;
                frame_d[219:200] = {pend_data_q, 4'b0};
            end
        end
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (pcm_out_valid[k]) begin
                tx_tag[12-k]                  = 1'b1;
                pcm_slot                      = '0;
                pcm_slot[19 -: SAMPLE_W]      = pcm_out[k*SAMPLE_W +: SAMPLE_W];
                frame_d[199-20*k -: 20]       = pcm_slot;
            end
        end
        frame_d[255:240] = tx_tag;
    end

    always_ff @(posedge ac97_bitclk or negedge ac97_rst_b) begin
        if (!ac97_rst_b) begin
            bit_cnt_q      <= 8'hFF;
            ac97_sdata_out <= 1'b0;
            ac97_sync      <= 1'b0;
            ac97_reset_b   <= 1'b0;
            frame_strobe   <= 1'b0;
            tx_q           <= '0;
            pending_q      <= 1'b0;
            pend_write_q   <= 1'b0;
            pend_addr_q    <= '0;
            pend_data_q    <= '0;
            codec_ready    <= 1'b0;
            status_valid   <= 1'b0;
            status_addr    <= '0;
            status_data    <= '0;
            pcm_in_valid   <= '0;
            pcm_in_l       <= '0;
            pcm_in_r       <= '0;
        end else begin
            bit_cnt_q    <= bit_cnt_d;
            ac97_sync    <= sync_d;
            ac97_reset_b <= 1'b1;
            frame_strobe <= frame_end;
            status_valid <= 1'b0;
            pcm_in_valid <= '0;
            if (frame_end) begin
                ac97_sdata_out <= frame_d[255];
                tx_q           <= {frame_d[254:0], 1'b0};
                pending_q      <= 1'b0;
                codec_ready    <= rx_q[255];
                if (rx_q[254] && rx_q[253]) begin
                    status_valid <= 1'b1;
                    status_addr  <= rx_q[238:232];
                    status_data  <= rx_q[219:204];
                end
                if (rx_q[252]) begin
                    pcm_in_valid[0] <= 1'b1;
                    pcm_in_l        <= rx_q[199 -: SAMPLE_W];
                end
                if (rx_q[251]) begin
                    pcm_in_valid[1] <= 1'b1;
                    pcm_in_r        <= rx_q[179 -: SAMPLE_W];
                end
            end else begin
                ac97_sdata_out <= tx_q[255];
                tx_q           <= {tx_q[254:0], 1'b0};
            end
            // Accept cannot coincide with a load: ready is low whenever a command is pending.
            if (cmd_accept) begin
                pending_q    <= 1'b1;
                pend_write_q <= cmd_write;
                pend_addr_q  <= cmd_addr;
                pend_data_q  <= cmd_data;
            end
        end
    end

    always_ff @(negedge ac97_bitclk or negedge ac97_rst_b) begin
        if (!ac97_rst_b) begin
            rx_q <= '0;
        end else begin
            rx_q[8'd255 - bit_cnt_q] <= ac97_sdata_in;
        end
    end

endmodule

// File: doc/ac97_link_engine.md
# ac97_link_engine

Parametrised AC-link frame engine between the codec pins and the audio/config logic. Serialises 256-bit frames (tag, command slots 1–2, up to ten PCM slots) onto the AC-link with registered outputs. Deserialises the incoming frame into codec-ready, register-status and stereo PCM-in outputs. Replaces the fixed-width link plus free-running config path with a `cmd_valid`/`cmd_ready` register-access handshake.

## Interface
- `SAMPLE_W`, 20: PCM sample width, 1..20; left-justified in 20-bit slot.
- `NUM_CH`, 2: output PCM channels, 1..10; channel k maps to slot 3+k.
- `ac97_bitclk` in 1: sole clock. Rising edge drives, falling edge samples `ac97_sdata_in`.
- `ac97_rst_b` in 1: asynchronous, active-low reset.
- `ac97_sdata_in` in 1: serial data from codec.
- `ac97_sdata_out` out 1: serial data to codec, registered.
- `ac97_sync` out 1: frame sync, registered.
- `ac97_reset_b` out 1: codec reset, registered; 0 in reset, 1 from first edge after release.
- `frame_strobe` out 1: one-cycle pulse at frame start.
- `pcm_out` in NUM_CH*SAMPLE_W: channel k at bits [k*SAMPLE_W +: SAMPLE_W].
- `pcm_out_valid` in NUM_CH: per-channel slot valid.
- `cmd_valid` in 1, `cmd_ready` out 1: command handshake.
- `cmd_write` in 1: 1 = write, 0 = read.
- `cmd_addr` in 7, `cmd_data` in 16: register address and write data.
- `codec_ready` out 1: tag bit 15 of last received frame.
- `status_valid` out 1, `status_addr` out 7, `status_data` out 16: register read-back.
- `pcm_in_valid` out 2: {right, left} slot-valid pulses.
- `pcm_in_l`, `pcm_in_r` out SAMPLE_W: PCM-in samples.

## Operation
- 8-bit `bit_cnt` = index of bit currently on the link. Increments on every rising edge, wrapping 255->0. The 255->0 edge is the frame boundary (B).
- At B:
  - Load 256-bit tx shadow.
  - Tag: bit15 = 1. Bit14 = slot1 valid. Bit13 = slot2 valid. Bits 12..3 = slots 3..12 valid (PCM valid for mapped channels, 0 otherwise). Bits 2..0 = 0.
  - Slot fields are zero when their tag bit is 0.
  - Transmit order is MSB first: tag[15] at bit 0, slot n bit 19 at index 16+20(n-1).
- Command path:
  - Holds one pending command. `cmd_ready` = !pending.
  - Accept on any rising edge with `cmd_valid && cmd_ready`.
  - At B, a pending command is loaded into the frame and pending clears. Slot1 = {~cmd_write, addr, 12'b0}. Slot2 = {data, 4'b0}, valid only for writes. Read: slot1 valid only.
  - A command accepted on the B edge itself misses that frame and goes in the next.
- PCM out: `pcm_out`/`pcm_out_valid` are sampled only at B. Slot = {sample, (20-SAMPLE_W) zeros}.
- Receive path:
  - Falling edge: `rx[bit_cnt] <= ac97_sdata_in`.
  - At B, decode the completed frame:
    - `codec_ready` <= rx tag bit15.
    - If tag bits 14 and 13 are set: `status_valid` pulses, `status_addr` = slot1[18:12], `status_data` = slot2[19:4].
    - Slot 3/4 valid tags pulse `pcm_in_valid[0]`/`[1]`, with samples = slot[19 -: SAMPLE_W].
  - Data outputs hold between pulses.

## Timing
- Reset values:
  - `bit_cnt` = 255, `ac97_sdata_out` = 0, `ac97_sync` = 0, `ac97_reset_b` = 0.
  - `frame_strobe` = 0, `cmd_ready` = 1, pending cleared.
  - `codec_ready` = 0, all valid pulses = 0, all data outputs = 0, tx/rx shadows = 0.
- First edge after release is a B.
- `ac97_sync` = 1 while `bit_cnt` ∈ {255, 0..14}, giving a 16-bit high window. The first frame after reset shows only 15 high bits.
- `ac97_sdata_out` updates on the rising edge that starts each bit, carrying tx[bit_cnt].
- `frame_strobe`, `status_valid` and `pcm_in_valid` are high exactly during the `bit_cnt` == 0 cycle.
- Command latency: accept -> tag/slot1 transmission at the next B (≤256 cycles). `cmd_ready` returns high the cycle after that B.
- Reset mid-frame aborts the frame, drops any pending command, and returns all outputs to reset values.

## Test plan
- Reset release, codec drives tag bit15 = 1 -> sync high for bit_cnt 0..14, then 255 and 0..14 every 256 cycles; `codec_ready` = 1 at the second B.
- `NUM_CH`=2, `SAMPLE_W`=16, `pcm_out`={16'h8001, 16'h7FFE}, valid=2'b11 -> tag = 16'h9800; slot3 = 20'h7FFE0; slot4 = 20'h80010.
- Write addr 7'h02, data 16'h0808 mid-frame -> `cmd_ready` low. Next frame: tag bits14/13 = 1, slot1 = 20'h02000, slot2 = 20'h08080. `cmd_ready` high afterwards.
- Read addr 7'h7C issued on the B edge -> not in the current frame. Next frame: slot1 = 20'hFC000, slot2 invalid and zero.
- Codec returns tag 16'hE000 with slot1 = 20'h7C000, slot2 = 20'h41440 -> `status_valid` pulses 1 cycle, `status_addr` = 7'h7C, `status_data` = 16'h4144.
- Reset asserted at bit_cnt = 100 with a command pending -> all outputs return to reset values immediately; after release, no command is transmitted.
